// File: rtl/sda_axil_pkg.sv
// Shared definitions for the AXI4-Lite to register-bus bridge: FSM encoding,
// response codes and the default access timeout.
package sda_axil_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WR_COLLECT = 3'd1,
        ST_WR_ACCESS  = 3'd2,
        ST_WR_RESP    = 3'd3,
        ST_RD_ACCESS  = 3'd4,
        ST_RD_RESP    = 3'd5
    } bridge_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 32'd64;

    // True while a register access is in flight and regAck is meaningful.
    function automatic logic is_access(input bridge_state_e state);
        return (state == ST_WR_ACCESS) || (state == ST_RD_ACCESS);
    endfunction

endpackage

// File: rtl/sda_reg_timeout.sv
// Watchdog for one register access: armed by start, disarmed by ack, and
// flags expired in the last of TimeoutCycles unacknowledged cycles.
module sda_reg_timeout
    import sda_axil_pkg::*;
#(
    parameter int unsigned TimeoutCycles = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic srst,
    input  logic start,
    input  logic ack,
    output logic expired
);

    localparam int unsigned CntWidth = $clog2(TimeoutCycles + 32'd1);

    logic                r_run;
    logic [CntWidth-1:0] r_count;
    logic                w_last;

    assign w_last  = (r_count == CntWidth'(TimeoutCycles - 32'd1));
    assign expired = r_run && !ack && w_last;

    // Count cycles of the current access; restart on every new access.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_run   <= 1'b0;
            r_count <= '0;
        end else if (start) begin
            r_run   <= 1'b1;
            r_count <= '0;
        end else if (ack || expired) begin
            r_run   <= 1'b0;
            r_count <= '0;
        end else if (r_run) begin
            r_count <= r_count + CntWidth'(1);
        end else begin
            r_count <= r_count;
        end
    end

endmodule

// File: rtl/sda_axil_reg_bridge.sv
// AXI4-Lite slave that turns each transaction into one request/acknowledge
// access on the register bus. Define SDA_REG_TIMEOUT_EN to build the access timeout.
module sda_axil_reg_bridge
    import sda_axil_pkg::*;
#(
    parameter int unsigned RegAddrWidth  = 32'd7,
    parameter int unsigned TimeoutCycles = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [RegAddrWidth-1:0] s_awaddr,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    input  logic [31:0]             s_wdata,
    input  logic [3:0]              s_wstrb,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    output logic [1:0]              s_bresp,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    input  logic [RegAddrWidth-1:0] s_araddr,
    output logic                    s_rvalid,
    input  logic                    s_rready,
    output logic [31:0]             s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    regReq,
    input  logic                    regAck,
    output logic                    regWriteEn,
    output logic [RegAddrWidth-1:0] regAddr,
    output logic [31:0]             regWData,
    output logic [3:0]              regWStrb,
    input  logic [31:0]             regRData
);

    bridge_state_e           r_state;
    logic                    r_aw_got;
    logic                    r_w_got;
    logic [RegAddrWidth-1:0] r_addr;
    logic [31:0]             r_wdata;
    logic [3:0]              r_wstrb;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_ar_hs;
    logic w_wr_go;
    logic w_rd_go;
    logic w_ack;
    logic w_timeout;

    // Ready decode; a pending write blocks AR so the write wins a same-cycle race.
    always_comb begin
        s_awready = 1'b0;
        s_wready  = 1'b0;
        s_arready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                s_awready = 1'b1;
                s_wready  = 1'b1;
                s_arready = !(s_awvalid || s_wvalid);
            end
            ST_WR_COLLECT: begin
                s_awready = !r_aw_got;
                s_wready  = !r_w_got;
            end
            default: begin
                s_awready = 1'b0;
                s_wready  = 1'b0;
                s_arready = 1'b0;
            end
        endcase
    end

    assign w_aw_hs = s_awvalid && s_awready;
    assign w_w_hs  = s_wvalid && s_wready;
    assign w_ar_hs = s_arvalid && s_arready;

    assign w_wr_go = ((r_state == ST_IDLE) && w_aw_hs && w_w_hs) ||
                     ((r_state == ST_WR_COLLECT) && (r_aw_got || w_aw_hs) && (r_w_got || w_w_hs));
    assign w_rd_go = (r_state == ST_IDLE) && w_ar_hs;
    assign w_ack   = regAck && is_access(r_state);

`ifdef SDA_REG_TIMEOUT_EN
    sda_reg_timeout #(
        .TimeoutCycles (TimeoutCycles)
    ) u_timeout (
        .clk     (clk),
        .srst    (srst),
        .start   (w_wr_go || w_rd_go),
        .ack     (w_ack),
        .expired (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    // Address and data capture at their handshakes; held for the whole access.
    always_ff @(posedge clk) begin
        if (w_aw_hs) begin
            r_addr <= s_awaddr;
        end else if (w_ar_hs) begin
            r_addr <= s_araddr;
        end else begin
            r_addr <= r_addr;
        end
        if (w_w_hs) begin
            r_wdata <= s_wdata;
            r_wstrb <= s_wstrb;
        end else begin
            r_wdata <= r_wdata;
            r_wstrb <= r_wstrb;
        end
    end

    assign regAddr  = r_addr;
    assign regWData = r_wdata;
    assign regWStrb = r_wstrb;

    // Transaction FSM with registered request and response outputs.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_state    <= ST_IDLE;
            r_aw_got   <= 1'b0;
            r_w_got    <= 1'b0;
            regReq     <= 1'b0;
            regWriteEn <= 1'b0;
            s_bvalid   <= 1'b0;
            s_bresp    <= RESP_OKAY;
            s_rvalid   <= 1'b0;
            s_rresp    <= RESP_OKAY;
            s_rdata    <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_wr_go) begin
                        r_state    <= ST_WR_ACCESS;
                        regReq     <= 1'b1;
                        regWriteEn <= 1'b1;
                    end else if (w_aw_hs || w_w_hs) begin
                        r_state  <= ST_WR_COLLECT;
                        r_aw_got <= w_aw_hs;
                        r_w_got  <= w_w_hs;
                    end else if (w_rd_go) begin
                        r_state    <= ST_RD_ACCESS;
                        regReq     <= 1'b1;
                        regWriteEn <= 1'b0;
                    end
                end
                ST_WR_COLLECT: begin
                    if (w_wr_go) begin
                        r_state    <= ST_WR_ACCESS;
                        r_aw_got   <= 1'b0;
                        r_w_got    <= 1'b0;
                        regReq     <= 1'b1;
                        regWriteEn <= 1'b1;
                    end
                end
                ST_WR_ACCESS: begin
                    if (w_ack || w_timeout) begin
                        r_state  <= ST_WR_RESP;
                        regReq   <= 1'b0;
                        s_bvalid <= 1'b1;
                        s_bresp  <= w_ack ? RESP_OKAY : RESP_SLVERR;
                    end
                end
                ST_WR_RESP: begin
                    if (s_bready) begin
                        r_state  <= ST_IDLE;
                        s_bvalid <= 1'b0;
                    end
                end
                ST_RD_ACCESS: begin
                    if (w_ack || w_timeout) begin
                        r_state  <= ST_RD_RESP;
                        regReq   <= 1'b0;
                        s_rvalid <= 1'b1;
                        s_rresp  <= w_ack ? RESP_OKAY : RESP_SLVERR;
                        s_rdata  <= w_ack ? regRData : 32'd0;
                    end
                end
                ST_RD_RESP: begin
                    if (s_rready) begin
                        r_state  <= ST_IDLE;
                        s_rvalid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    regReq  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sda_axil_reg_bridge.sv
// Directed scoreboard bench for sda_axil_reg_bridge; the timeout scenario
// follows SDA_REG_TIMEOUT_EN.
module tb_sda_axil_reg_bridge;
    import sda_axil_pkg::*;

    localparam int unsigned AW = 32'd7;
    localparam int unsigned TO = 32'd8;

    logic          clk = 1'b0;
    logic          srst;
    logic          s_awvalid, s_awready;
    logic [AW-1:0] s_awaddr;
    logic          s_wvalid, s_wready;
    logic [31:0]   s_wdata;
    logic [3:0]    s_wstrb;
    logic          s_bvalid, s_bready;
    logic [1:0]    s_bresp;
    logic          s_arvalid, s_arready;
    logic [AW-1:0] s_araddr;
    logic          s_rvalid, s_rready;
    logic [31:0]   s_rdata;
    logic [1:0]    s_rresp;
    logic          regReq, regAck, regWriteEn;
    logic [AW-1:0] regAddr;
    logic [31:0]   regWData;
    logic [3:0]    regWStrb;
    logic [31:0]   regRData;

    always #5 clk = ~clk;

    sda_axil_reg_bridge #(.RegAddrWidth(AW), .TimeoutCycles(TO)) dut (
        .clk(clk), .srst(srst),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .regReq(regReq), .regAck(regAck), .regWriteEn(regWriteEn), .regAddr(regAddr),
        .regWData(regWData), .regWStrb(regWStrb), .regRData(regRData)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [3:0]    strb;
        logic [31:0]   rdata;
    } acc_t;

    typedef struct {
        logic        is_rd;
        logic [1:0]  resp;
        logic [31:0] data;
    } rsp_t;

    acc_t acc_q[$];
    rsp_t rsp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
        acc_q.push_back('{we: 1'b1, addr: a, wdata: d, strb: s, rdata: 32'd0});
        rsp_q.push_back('{is_rd: 1'b0, resp: RESP_OKAY, data: 32'd0});
    endtask

    task automatic push_read(input logic [AW-1:0] a, input logic [31:0] rd);
        acc_q.push_back('{we: 1'b0, addr: a, wdata: 32'd0, strb: 4'd0, rdata: rd});
        rsp_q.push_back('{is_rd: 1'b1, resp: RESP_OKAY, data: rd});
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!regReq && n < 40) begin
            tick();
            n++;
        end
        check($sformatf("%s.req_seen", tag), {31'd0, regReq}, 32'd1);
    endtask

    // Slave side: expect the next queued access, hold it for 'hold' cycles, then ack.
    task automatic serve(input string tag, input int hold);
        acc_t a;
        a = acc_q.pop_front();
        wait_req(tag);
        for (int i = 0; i < hold; i++) begin
            if (i > 0) tick();
            check($sformatf("%s.req_c%0d", tag, i), {31'd0, regReq}, 32'd1);
            check($sformatf("%s.we_c%0d", tag, i), {31'd0, regWriteEn}, {31'd0, a.we});
            check($sformatf("%s.addr_c%0d", tag, i), {25'd0, regAddr}, {25'd0, a.addr});
            if (a.we) begin
                check($sformatf("%s.wdata_c%0d", tag, i), regWData, a.wdata);
                check($sformatf("%s.wstrb_c%0d", tag, i), {28'd0, regWStrb}, {28'd0, a.strb});
            end
        end
        regAck   = 1'b1;
        regRData = a.rdata;
        tick();
        regAck   = 1'b0;
        regRData = 32'd0;
        check($sformatf("%s.req_drop", tag), {31'd0, regReq}, 32'd0);
    endtask

    // Master side: expect the next queued response, stall ready, then accept it.
    task automatic collect(input string tag, input int stall);
        rsp_t r;
        r = rsp_q.pop_front();
        for (int i = 0; i <= stall; i++) begin
            if (i > 0) tick();
            if (r.is_rd) begin
                check($sformatf("%s.rvalid_c%0d", tag, i), {31'd0, s_rvalid}, 32'd1);
                check($sformatf("%s.rdata_c%0d", tag, i), s_rdata, r.data);
                check($sformatf("%s.rresp_c%0d", tag, i), {30'd0, s_rresp}, {30'd0, r.resp});
            end else begin
                check($sformatf("%s.bvalid_c%0d", tag, i), {31'd0, s_bvalid}, 32'd1);
                check($sformatf("%s.bresp_c%0d", tag, i), {30'd0, s_bresp}, {30'd0, r.resp});
            end
        end
        s_rready = r.is_rd;
        s_bready = !r.is_rd;
        tick();
        s_rready = 1'b0;
        s_bready = 1'b0;
        check($sformatf("%s.valid_drop", tag), {31'd0, (s_rvalid | s_bvalid)}, 32'd0);
    endtask

    task automatic send_aw_w(input string tag, input logic [AW-1:0] a, input logic [31:0] d,
                             input logic [3:0] s);
        s_awvalid = 1'b1; s_awaddr = a;
        s_wvalid  = 1'b1; s_wdata  = d; s_wstrb = s;
        #1;
        check($sformatf("%s.awready", tag), {31'd0, s_awready}, 32'd1);
        check($sformatf("%s.wready", tag), {31'd0, s_wready}, 32'd1);
        @(posedge clk);
        #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        s_wdata   = 32'd0; s_awaddr = '0;
        check($sformatf("%s.req_next", tag), {31'd0, regReq}, 32'd1);
    endtask

    task automatic send_ar(input string tag, input logic [AW-1:0] a);
        s_arvalid = 1'b1; s_araddr = a;
        #1;
        check($sformatf("%s.arready", tag), {31'd0, s_arready}, 32'd1);
        @(posedge clk);
        #1;
        s_arvalid = 1'b0; s_araddr = '0;
        check($sformatf("%s.req_next", tag), {31'd0, regReq}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish observed=hang expected=finish");
        $fatal(1);
    end

    initial begin
        srst = 1'b1;
        s_awvalid = 1'b0; s_awaddr = '0; s_wvalid = 1'b0; s_wdata = 32'd0; s_wstrb = 4'd0;
        s_bready = 1'b0; s_arvalid = 1'b0; s_araddr = '0; s_rready = 1'b0;
        regAck = 1'b0; regRData = 32'd0;

        // Reset state
        repeat (3) tick();
        check("rst.regReq", {31'd0, regReq}, 32'd0);
        check("rst.bvalid", {31'd0, s_bvalid}, 32'd0);
        check("rst.rvalid", {31'd0, s_rvalid}, 32'd0);
        check("rst.bresp", {30'd0, s_bresp}, 32'd0);
        check("rst.rresp", {30'd0, s_rresp}, 32'd0);
        check("rst.rdata", s_rdata, 32'd0);
        srst = 1'b0;
        tick();
        check("idle.awready", {31'd0, s_awready}, 32'd1);
        check("idle.wready", {31'd0, s_wready}, 32'd1);
        check("idle.arready", {31'd0, s_arready}, 32'd1);

        // Stray acknowledge while idle
        regAck = 1'b1; regRData = 32'hFFFF_FFFF;
        tick();
        regAck = 1'b0; regRData = 32'd0;
        tick();
        check("stray.bvalid", {31'd0, s_bvalid}, 32'd0);
        check("stray.rvalid", {31'd0, s_rvalid}, 32'd0);
        check("stray.regReq", {31'd0, regReq}, 32'd0);

        // Write with AW and W together, slave acks in the second request cycle
        push_write(7'h44, 32'hA5A5_0001, 4'hF);
        send_aw_w("wr44", 7'h44, 32'hA5A5_0001, 4'hF);
        serve("wr44", 2);
        collect("wr44", 0);

        // W three cycles ahead of AW
        push_write(7'h2C, 32'hDEAD_BEEF, 4'b0110);
        s_wvalid = 1'b1; s_wdata = 32'hDEAD_BEEF; s_wstrb = 4'b0110;
        tick();
        s_wvalid = 1'b0; s_wdata = 32'd0; s_wstrb = 4'd0;
        check("wfirst.wready", {31'd0, s_wready}, 32'd0);
        check("wfirst.awready", {31'd0, s_awready}, 32'd1);
        check("wfirst.arready", {31'd0, s_arready}, 32'd0);
        check("wfirst.regReq", {31'd0, regReq}, 32'd0);
        tick();
        tick();
        s_awvalid = 1'b1; s_awaddr = 7'h2C;
        tick();
        s_awvalid = 1'b0; s_awaddr = '0;
        check("wfirst.req_next", {31'd0, regReq}, 32'd1);
        serve("wfirst", 1);
        collect("wfirst", 1);
        repeat (3) tick();
        check("wfirst.single", {31'd0, regReq}, 32'd0);

        // Read with response stalled three cycles
        push_read(7'h48, 32'h1234_5678);
        send_ar("rd48", 7'h48);
        serve("rd48", 1);
        collect("rd48", 3);

        // Write and read valid in the same idle cycle
        push_write(7'h10, 32'h0BAD_CAFE, 4'b1001);
        push_read(7'h14, 32'h5555_AAAA);
        s_awvalid = 1'b1; s_awaddr = 7'h10; s_wvalid = 1'b1; s_wdata = 32'h0BAD_CAFE;
        s_wstrb = 4'b1001; s_arvalid = 1'b1; s_araddr = 7'h14;
        #1;
        check("race.arready_first", {31'd0, s_arready}, 32'd0);
        check("race.awready_first", {31'd0, s_awready}, 32'd1);
        @(posedge clk);
        #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_awaddr = '0; s_wdata = 32'd0;
        check("race.arready_busy", {31'd0, s_arready}, 32'd0);
        serve("race_wr", 1);
        collect("race_wr", 0);
        check("race.arready_idle", {31'd0, s_arready}, 32'd1);
        tick();
        s_arvalid = 1'b0; s_araddr = '0;
        check("race.rd_req", {31'd0, regReq}, 32'd1);
        serve("race_rd", 1);
        collect("race_rd", 0);

        // Unmapped address: nobody acknowledges
        regRData = 32'hFFFF_FFFF;
        send_ar("unmapped", 7'h7C);
`ifdef SDA_REG_TIMEOUT_EN
        rsp_q.push_back('{is_rd: 1'b1, resp: RESP_SLVERR, data: 32'd0});
        begin
            int n = 0;
            while (regReq && n < 40) begin
                n++;
                tick();
            end
            check("unmapped.req_cycles", n, TO);
        end
        check("unmapped.req_low", {31'd0, regReq}, 32'd0);
        regRData = 32'd0;
        collect("unmapped", 0);
`else
        repeat (20) begin
            tick();
            check("unmapped.req_held", {31'd0, regReq}, 32'd1);
        end
        regRData = 32'd0;
        push_read(7'h7C, 32'hCAFE_F00D);
        serve("unmapped", 1);
        collect("unmapped", 0);
`endif

        // Reset in the middle of a write access
        send_aw_w("abort", 7'h30, 32'h1111_2222, 4'hF);
        tick();
        srst = 1'b1;
        tick();
        srst = 1'b0;
        check("abort.req_low", {31'd0, regReq}, 32'd0);
        repeat (3) begin
            tick();
            check("abort.no_bvalid", {31'd0, s_bvalid}, 32'd0);
        end
        push_write(7'h34, 32'h3333_4444, 4'b0011);
        send_aw_w("after", 7'h34, 32'h3333_4444, 4'b0011);
        serve("after", 1);
        collect("after", 0);

        check("sb.empty", acc_q.size() + rsp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
